// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_unit
//  Description : PC generation and fetch queue feeding decode/branch. Fetches
//                sequentially (not-taken), one outstanding imem request,
//                redirects on j_accept. Optional macro: MISALIGN_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        j_accept,
    input  logic        j_wait,
    input  logic [31:0] j_addr,
    output logic        fetch_misalign
);

    localparam int                c_PW         = $clog2(QDEPTH);
    localparam int                c_CW         = c_PW + 1;
    localparam logic [c_CW-1:0]   c_QDEPTH     = c_CW'(QDEPTH);
    localparam logic [c_CW-1:0]   c_CNT_ONE    = c_CW'(1);
    localparam logic [c_PW-1:0]   c_PTR_ONE    = c_PW'(1);
    localparam logic [31:0]       c_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          r_state_q, w_state_d;
    logic [31:0]     r_pc_q, w_pc_d;
    logic [c_PW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_PW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_CW-1:0] r_count_q, w_count_d;
    logic            r_misalign_q, w_misalign_d;
    logic [31:0]     r_pc_mem_q    [QDEPTH];
    logic [31:0]     r_instr_mem_q [QDEPTH];

    logic            w_if_valid;
    logic            w_redirect;
    logic            w_pop;
    logic            w_push;
    logic            w_req;
    logic            w_trap;
    logic [c_CW-1:0] w_count_after_pop;

    always_comb begin
        w_if_valid = (r_count_q != '0);
        // A j_accept with an empty head is illegal and simply ignored.
        w_redirect = j_accept & w_if_valid;
        w_pop      = w_if_valid & id_ready & ~j_wait & ~w_redirect;
`ifdef MISALIGN_TRAP_EN
        w_trap     = w_redirect & (j_addr[1:0] != 2'b00);
`else
        w_trap     = 1'b0;
`endif
        w_count_after_pop = r_count_q - (w_pop ? c_CNT_ONE : '0);
        w_req  = ~reset & (r_state_q == S_IDLE) & ~w_redirect & ~r_misalign_q &
                 (w_count_after_pop < c_QDEPTH);
        w_push = (r_state_q == S_WAIT) & imem_rvalid & ~w_redirect;

        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE:  if (w_req) w_state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid)     w_state_d = S_IDLE;
                else if (w_redirect) w_state_d = S_FLUSH;
            end
            S_FLUSH: if (imem_rvalid) w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase

        w_pc_d = r_pc_q;
        if (w_redirect)  w_pc_d = w_trap ? r_pc_q : (j_addr & c_ALIGN_MASK);
        else if (w_push) w_pc_d = r_pc_q + 32'd4;

        w_rd_ptr_d = r_rd_ptr_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_count_d  = r_count_q;
        if (w_redirect) begin
            w_rd_ptr_d = '0;
            w_wr_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (w_pop)  w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
            if (w_push) w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
            w_count_d = w_count_after_pop + (w_push ? c_CNT_ONE : '0);
        end

        w_misalign_d = r_misalign_q | w_trap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= S_IDLE;
            r_pc_q       <= RESET_PC;
            r_rd_ptr_q   <= '0;
            r_wr_ptr_q   <= '0;
            r_count_q    <= '0;
            r_misalign_q <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_pc_mem_q[i]    <= '0;
                r_instr_mem_q[i] <= '0;
            end
        end else begin
            r_state_q    <= w_state_d;
            r_pc_q       <= w_pc_d;
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_count_q    <= w_count_d;
            r_misalign_q <= w_misalign_d;
            if (w_push) begin
                r_pc_mem_q[r_wr_ptr_q]    <= r_pc_q;
                r_instr_mem_q[r_wr_ptr_q] <= imem_rdata;
            end
        end
    end

    assign imem_req       = w_req;
    assign imem_addr      = r_pc_q;
    assign if_valid       = w_if_valid;
    assign if_pc          = r_pc_mem_q[r_rd_ptr_q];
    assign if_instr       = r_instr_mem_q[r_rd_ptr_q];
    assign fetch_misalign = r_misalign_q;

endmodule
`default_nettype wire
